// File: rtl/axi4_burst_ram.sv
// axi4_burst_ram: AXI4 slave serving full-width INCR bursts from an on-chip register array.
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding burst each.
// Optional macro AXI4_BURST_RAM_RD_PIPE_EN adds a second read register stage with a 2-entry skid.
module axi4_burst_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int unsigned WORD_LSB = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_W    = ADDR_WIDTH - WORD_LSB;
    localparam int unsigned DEPTH    = 2 ** IDX_W;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-offset bits below the word index carry no meaning for full-width bursts.
    logic unused_c;
    assign unused_c = ^{s_axi_awaddr, s_axi_araddr};

    logic [IDX_W-1:0] aw_word_c;
    logic [IDX_W-1:0] ar_word_c;
    assign aw_word_c = s_axi_awaddr[ADDR_WIDTH-1:WORD_LSB];
    assign ar_word_c = s_axi_araddr[ADDR_WIDTH-1:WORD_LSB];

    assign s_axi_rresp = RESP_OKAY;

    // ---------------------------------------------------------------- write path
    w_state_t         w_state;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_cnt;
    logic             w_err;
    logic             w_beat_c;
    logic             w_last_err_c;

    assign w_beat_c     = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;
    assign w_last_err_c = s_axi_wlast != (w_cnt == 8'd0);

    // Write FSM: accept AW, count beats by awlen, report SLVERR on any misplaced wlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= RESP_OKAY;
            w_idx         <= '0;
            w_cnt         <= '0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        s_axi_bid     <= s_axi_awid;
                        w_idx         <= aw_word_c;
                        w_cnt         <= s_axi_awlen;
                        w_err         <= 1'b0;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat_c) begin
                        w_idx <= w_idx + IDX_W'(1);
                        w_cnt <= w_cnt - 8'd1;
                        w_err <= w_err | w_last_err_c;
                        if (w_cnt == 8'd0) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (w_err | w_last_err_c) ? RESP_SLVERR : RESP_OKAY;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bvalid && s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Array write port: byte-lane enables, contents never reset.
    always_ff @(posedge clk) begin
        if (w_beat_c) begin
            for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------- read path
    r_state_t         r_state;
    logic [IDX_W-1:0] r_idx;
    logic             ar_hs_c;
    logic             r_pop_c;

    assign ar_hs_c = s_axi_arvalid && s_axi_arready;
    assign r_pop_c = s_axi_rvalid && s_axi_rready;

`ifdef AXI4_BURST_RAM_RD_PIPE_EN
    logic [7:0]            r_icnt;
    logic                  s1_valid;
    logic                  s1_last;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [DATA_WIDTH-1:0] q_data1;
    logic                  q_last1;
    logic [1:0]            q_cnt;
    logic [1:0]            q_cnt_n_c;
    logic                  r_issue_c;
    logic                  r_issue_last_c;
    logic [IDX_W-1:0]      r_issue_idx_c;

    // Fetch issue: first beat on the AR handshake, later beats only while the skid has room.
    always_comb begin
        r_issue_c      = 1'b0;
        r_issue_last_c = 1'b0;
        r_issue_idx_c  = r_idx;
        if (r_state == R_IDLE) begin
            r_issue_c      = ar_hs_c;
            r_issue_last_c = s_axi_arlen == 8'd0;
            r_issue_idx_c  = ar_word_c;
        end else if ((r_icnt != 8'd0) &&
                     (({1'b0, q_cnt} + 3'(s1_valid)) < (3'd2 + 3'(r_pop_c)))) begin
            r_issue_c      = 1'b1;
            r_issue_last_c = r_icnt == 8'd1;
        end
    end

    assign q_cnt_n_c = q_cnt - 2'(r_pop_c) + 2'(s1_valid);

    // Read FSM: latch the request, step the fetch address, finish on the last R handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rid     <= '0;
            r_idx         <= '0;
            r_icnt        <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (ar_hs_c) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rid     <= s_axi_arid;
                        r_idx         <= ar_word_c + IDX_W'(1);
                        r_icnt        <= s_axi_arlen;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_issue_c) begin
                        r_idx  <= r_idx + IDX_W'(1);
                        r_icnt <= r_icnt - 8'd1;
                    end
                    if (r_pop_c && s_axi_rlast) begin
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // First stage: registered array read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= r_issue_c;
            if (r_issue_c) begin
                s1_data <= mem[r_issue_idx_c];
                s1_last <= r_issue_last_c;
            end
        end
    end

    // Output skid: head entry drives R directly, second entry absorbs backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_cnt        <= '0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rlast  <= 1'b0;
            q_data1      <= '0;
            q_last1      <= 1'b0;
        end else begin
            q_cnt        <= q_cnt_n_c;
            s_axi_rvalid <= q_cnt_n_c != 2'd0;
            if (r_pop_c) begin
                s_axi_rdata <= q_data1;
                s_axi_rlast <= (q_cnt == 2'd2) && q_last1;
            end
            if (s1_valid) begin
                if ((q_cnt - 2'(r_pop_c)) == 2'd0) begin
                    s_axi_rdata <= s1_data;
                    s_axi_rlast <= s1_last;
                end else begin
                    q_data1 <= s1_data;
                    q_last1 <= s1_last;
                end
            end
        end
    end
`else
    logic [7:0] r_cnt;

    // Read FSM: one registered array read per R handshake; rdata holds while rready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (ar_hs_c) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rdata   <= mem[ar_word_c];
                        s_axi_rlast   <= s_axi_arlen == 8'd0;
                        s_axi_rvalid  <= 1'b1;
                        r_idx         <= ar_word_c + IDX_W'(1);
                        r_cnt         <= s_axi_arlen;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_pop_c) begin
                        if (r_cnt == 8'd0) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            s_axi_rdata <= mem[r_idx];
                            s_axi_rlast <= r_cnt == 8'd1;
                            r_idx       <= r_idx + IDX_W'(1);
                            r_cnt       <= r_cnt - 8'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
`endif

endmodule
